// File: rtl/mod14_down_counter.sv
// mod14_down_counter: synchronous modulo-MODULUS down counter with parallel load,
// terminal-count decode and a cascadable borrow output. Counts MODULUS-1 down to 0,
// then wraps back to MODULUS-1 and pulses 'wrapped' for one cycle.

module mod14_down_counter_chk #(
    parameter int MODULUS = 14,
    parameter int WIDTH   = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] Q,
    input logic             tc,
    input logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    // Count never leaves the legal range, even right after a clamped load.
    a_range: assert property (@(posedge clk) disable iff (rst) Q <= MAX_CNT);

    // Terminal count is an exact decode of zero.
    a_tc: assert property (@(posedge clk) disable iff (rst) tc == (Q == {WIDTH{1'b0}}));

    // A wrap pulse is only ever seen alongside the top count value.
    a_wrap: assert property (@(posedge clk) disable iff (rst) wrapped |-> (Q == MAX_CNT));

endmodule

module mod14_down_counter #(
    parameter int MODULUS = 14,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             borrow,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_CNT  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             wrapped_r;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_next_s;
    logic             is_zero_s;

    // Out-of-range load values saturate to the top count so Q stays legal.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v > MAX_CNT) begin
            r = MAX_CNT;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Zero decode shared by tc, borrow and the wrap decision.
    always_comb begin
        is_zero_s = (q_r == ZERO_CNT);
    end

    // Next count and wrap flag for the load / count / hold cases (reset handled in the register).
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        if (load) begin
            q_next_s    = clamp_load(load_val);
            wrap_next_s = 1'b0;
        end else if (en) begin
            if (is_zero_s) begin
                q_next_s    = MAX_CNT;
                wrap_next_s = 1'b1;
            end else begin
                q_next_s    = q_r - ONE_CNT;
                wrap_next_s = 1'b0;
            end
        end else begin
            q_next_s    = q_r;
            wrap_next_s = 1'b0;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= ZERO_CNT;
            wrapped_r <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            wrapped_r <= wrap_next_s;
        end
    end

    // Output decode: tc and borrow are purely combinational on the registered count.
    always_comb begin
        Q       = q_r;
        wrapped = wrapped_r;
        tc      = is_zero_s;
        borrow  = is_zero_s & en & ~load & ~rst;
    end

    mod14_down_counter_chk #(
        .MODULUS(MODULUS),
        .WIDTH  (WIDTH)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .Q      (Q),
        .tc     (tc),
        .wrapped(wrapped)
    );

endmodule

// File: tb/tb_mod14_down_counter.sv
// Directed scoreboard bench for mod14_down_counter, including a two-stage cascade
// where stage 1 is enabled by stage 0's borrow.

module tb_mod14_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q0;
    logic       tc0;
    logic       borrow0;
    logic       wrapped0;
    logic [3:0] q1;
    logic       tc1;
    logic       borrow1;
    logic       wrapped1;
    logic       c_load = 1'b0;
    logic [3:0] c_load_val = 4'd0;

    int checks = 0;
    int errors = 0;

    // Software model state (integers, independent of the DUT)
    int m_q0;
    int m_q1;

    typedef struct {
        logic [3:0] q0;
        logic       w0;
        logic [3:0] q1;
        logic       w1;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mod14_down_counter #(.MODULUS(14), .WIDTH(4)) u_stage0 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .Q       (q0),
        .tc      (tc0),
        .borrow  (borrow0),
        .wrapped (wrapped0)
    );

    mod14_down_counter #(.MODULUS(14), .WIDTH(4)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .en      (borrow0),
        .load    (c_load),
        .load_val(c_load_val),
        .Q       (q1),
        .tc      (tc1),
        .borrow  (borrow1),
        .wrapped (wrapped1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step: check combinational outputs, predict, clock, compare registered outputs.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [3:0] lv, input string tag);
        exp_t x;
        exp_t y;
        int   nq0;
        int   nq1;
        logic nw0;
        logic nw1;
        logic bexp;
        rst = r; en = e; load = l; load_val = lv;
        #1;
        bexp = (m_q0 == 0) && e && !l && !r;
        chk({tag, ".tc"}, {7'd0, tc0}, {7'd0, (m_q0 == 0)});
        chk({tag, ".borrow"}, {7'd0, borrow0}, {7'd0, bexp});
        if (r) begin
            nq0 = 0; nw0 = 1'b0;
        end else if (l) begin
            nq0 = (int'(lv) > 13) ? 13 : int'(lv); nw0 = 1'b0;
        end else if (e) begin
            nq0 = (m_q0 + 13) % 14; nw0 = (m_q0 == 0);
        end else begin
            nq0 = m_q0; nw0 = 1'b0;
        end
        if (r) begin
            nq1 = 0; nw1 = 1'b0;
        end else if (bexp) begin
            nq1 = (m_q1 + 13) % 14; nw1 = (m_q1 == 0);
        end else begin
            nq1 = m_q1; nw1 = 1'b0;
        end
        x.q0 = 4'(nq0); x.w0 = nw0; x.q1 = 4'(nq1); x.w1 = nw1; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        m_q0 = nq0;
        m_q1 = nq1;
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 8'd1, 8'd0);
        end else begin
            y = sb.pop_front();
            chk({y.tag, ".Q"}, {4'd0, q0}, {4'd0, y.q0});
            chk({y.tag, ".wrapped"}, {7'd0, wrapped0}, {7'd0, y.w0});
            chk({y.tag, ".Q1"}, {4'd0, q1}, {4'd0, y.q1});
            chk({y.tag, ".wrapped1"}, {7'd0, wrapped1}, {7'd0, y.w1});
        end
    endtask

    initial begin
        // Bring both stages out of the unknown state
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd9;
        @(posedge clk);
        #1;
        m_q0 = 0;
        m_q1 = 0;

        // Reset held with en and load both high
        step(1'b1, 1'b1, 1'b1, 4'd9, "rst_hold0");
        step(1'b1, 1'b1, 1'b1, 4'd9, "rst_hold1");
        chk("rst.tc_direct", {7'd0, tc0}, 8'd1);
        chk("rst.q_direct", {4'd0, q0}, 8'd0);

        // Full cycle: 0 -> 13 .. 0 -> 13
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 4'd0, $sformatf("cycle%0d", i));
        chk("cycle.end_q", {4'd0, q0}, 8'd13);

        // Load and clamp
        step(1'b0, 1'b0, 1'b1, 4'd9, "load9");
        chk("load9.direct", {4'd0, q0}, 8'd9);
        step(1'b0, 1'b0, 1'b1, 4'd15, "load15");
        chk("load15.direct", {4'd0, q0}, 8'd13);
        step(1'b0, 1'b1, 1'b1, 4'd14, "load14");
        step(1'b0, 1'b0, 1'b1, 4'd5, "load5");
        step(1'b0, 1'b1, 1'b1, 4'd2, "load_en2");
        chk("load_en2.direct", {4'd0, q0}, 8'd2);

        // Hold at 7
        step(1'b0, 1'b0, 1'b1, 4'd7, "load7");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4'd0, $sformatf("hold%0d", i));
        chk("hold.direct", {4'd0, q0}, 8'd7);

        // Reset mid-count at Q=4
        step(1'b0, 1'b0, 1'b1, 4'd6, "load6");
        step(1'b0, 1'b1, 1'b0, 4'd0, "dec5");
        step(1'b0, 1'b1, 1'b0, 4'd0, "dec4");
        step(1'b1, 1'b1, 1'b0, 4'd0, "midrst");
        chk("midrst.direct", {4'd0, q0}, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0, $sformatf("resume%0d", i));
        chk("resume.direct", {4'd0, q0}, 8'd11);

        // Count to 0 then load with en high at Q==0
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 4'd0, $sformatf("to0_%0d", i));
        chk("to0.direct", {4'd0, q0}, 8'd0);
        step(1'b0, 1'b1, 1'b1, 4'd3, "load_at0");
        chk("load_at0.direct", {4'd0, q0}, 8'd3);

        // Cascade: 14*14 edges from reset returns both stages to 0
        step(1'b1, 1'b0, 1'b0, 4'd0, "casc_rst");
        for (int i = 0; i < 196; i++) step(1'b0, 1'b1, 1'b0, 4'd0, $sformatf("casc%0d", i));
        chk("casc.end_q0", {4'd0, q0}, 8'd0);
        chk("casc.end_q1", {4'd0, q1}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
